// File: rtl/l1_cache_pkg.sv
// Shared types and address-field helpers for the parametrised L1 lookup/fill/return path.
// Field widths are derived from the top-level parameters; extraction works on a widened address.
package l1_cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_WAIT,
        FILL,
        RESP
    } state_e;

    localparam int MAX_ADDR_W = 64;
    typedef logic [MAX_ADDR_W-1:0] addr_t;

    function automatic int calc_off_w(input int line_w, input int word_w);
        return $clog2(line_w / word_w);
    endfunction

    function automatic int calc_idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int calc_tag_w(input int addr_w, input int idx_w, input int off_w);
        return addr_w - idx_w - off_w;
    endfunction

    function automatic addr_t addr_off(input addr_t a, input int off_w);
        return a & ((addr_t'(1) << off_w) - addr_t'(1));
    endfunction

    function automatic addr_t addr_idx(input addr_t a, input int off_w, input int idx_w);
        return (a >> off_w) & ((addr_t'(1) << idx_w) - addr_t'(1));
    endfunction

    function automatic addr_t addr_tag(input addr_t a, input int off_w, input int idx_w);
        return a >> (off_w + idx_w);
    endfunction

endpackage

// File: rtl/l1_fill_return_ctrl_if.sv
// Client request/response and L2 line request/ack bundle for the L1 fill/return controller.
// slave is the controller's view; master is the client/L2 environment's view.
interface l1_fill_return_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int WORD_W = 32,
    parameter int LINE_W = 256
);
    logic              cl_req_valid;
    logic              cl_req_ready;
    logic [ADDR_W-1:0] cl_req_addr;
    logic              cl_rsp_valid;
    logic              cl_rsp_ready;
    logic [WORD_W-1:0] cl_rsp_data;
    logic [ADDR_W-1:0] cl_rsp_addr;
    logic              cl_rsp_hit;
    logic              l2_req_valid;
    logic              l2_req_ready;
    logic [ADDR_W-1:0] l2_req_addr;
    logic              l2_ack;
    logic [LINE_W-1:0] l2_data;

    modport slave (
        input  cl_req_valid, cl_req_addr, cl_rsp_ready, l2_req_ready, l2_ack, l2_data,
        output cl_req_ready, cl_rsp_valid, cl_rsp_data, cl_rsp_addr, cl_rsp_hit,
               l2_req_valid, l2_req_addr
    );

    modport master (
        output cl_req_valid, cl_req_addr, cl_rsp_ready, l2_req_ready, l2_ack, l2_data,
        input  cl_req_ready, cl_rsp_valid, cl_rsp_data, cl_rsp_addr, cl_rsp_hit,
               l2_req_valid, l2_req_addr
    );
endinterface

// File: rtl/l1_line_store.sv
// Direct-mapped tag/valid/data flop arrays with a combinational read port and one write port.
// Only the valid bits are reset; inv_all beats a same-cycle write so a cleared line stays invalid.
module l1_line_store #(
    parameter int NUM_LINES = 32,
    parameter int IDX_W     = 5,
    parameter int TAG_W     = 8,
    parameter int LINE_W    = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inv_all,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_line,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_line
);
    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tags_q  [NUM_LINES];
    logic [LINE_W-1:0]    lines_q [NUM_LINES];

    always_ff @(posedge clk) begin
        if (rst || inv_all) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tags_q[wr_idx]  <= wr_tag;
            lines_q[wr_idx] <= wr_line;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tags_q[rd_idx];
    assign rd_line  = lines_q[rd_idx];
endmodule

// File: rtl/l1_fill_return_ctrl.sv
// L1 lookup/fill/return controller: one outstanding client read, hit return or L2 line fill,
// saturating hit/miss counters, global invalidate and stray-ack detection.
module l1_fill_return_ctrl
    import l1_cache_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int WORD_W    = 32,
    parameter int LINE_W    = 256,
    parameter int NUM_LINES = 32,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    l1_fill_return_ctrl_if.slave bus,
    input  logic                 inv_all,
    output logic                 err_stray_ack,
    output logic [CNT_W-1:0]     hit_cnt,
    output logic [CNT_W-1:0]     miss_cnt
);
    localparam int OFF_W = calc_off_w(LINE_W, WORD_W);
    localparam int IDX_W = calc_idx_w(NUM_LINES);
    localparam int TAG_W = calc_tag_w(ADDR_W, IDX_W, OFF_W);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   req_addr_q;
    logic [OFF_W-1:0]    req_off;
    logic [IDX_W-1:0]    req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic                rd_valid;
    logic [TAG_W-1:0]    rd_tag;
    logic [LINE_W-1:0]   rd_line;
    logic [LINE_W-1:0]   fill_line_q;
    logic [WORD_W-1:0]   hit_word, fill_word;
    logic [WORD_W-1:0]   rsp_data_q;
    logic                rsp_hit_q;
    logic                hit;
    logic                fill_we;
    logic                err_q;
    logic [CNT_W-1:0]    hit_cnt_q, miss_cnt_q;

    assign req_off = OFF_W'(addr_off(addr_t'(req_addr_q), OFF_W));
    assign req_idx = IDX_W'(addr_idx(addr_t'(req_addr_q), OFF_W, IDX_W));
    assign req_tag = TAG_W'(addr_tag(addr_t'(req_addr_q), OFF_W, IDX_W));

    l1_line_store #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W),
        .LINE_W    (LINE_W)
    ) u_store (
        .clk      (clk),
        .rst      (rst),
        .inv_all  (inv_all),
        .rd_idx   (req_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .we       (fill_we),
        .wr_idx   (req_idx),
        .wr_tag   (req_tag),
        .wr_line  (fill_line_q)
    );

    // Reads the pre-clear valid bits, so an inv_all in the LOOKUP cycle does not affect this request.
    assign hit       = rd_valid && (rd_tag == req_tag);
    assign hit_word  = rd_line[int'(req_off) * WORD_W +: WORD_W];
    assign fill_word = fill_line_q[int'(req_off) * WORD_W +: WORD_W];
    assign fill_we   = (state_q == FILL);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (bus.cl_req_valid) state_d = LOOKUP;
            LOOKUP:    state_d = hit ? RESP : MISS_REQ;
            MISS_REQ:  if (bus.l2_req_ready) state_d = MISS_WAIT;
            MISS_WAIT: if (bus.l2_ack) state_d = FILL;
            FILL:      state_d = RESP;
            RESP:      if (bus.cl_rsp_ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr_q <= '0;
            rsp_data_q <= '0;
            rsp_hit_q  <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= bus.l2_ack && (state_q != MISS_WAIT);
            if (state_q == IDLE && bus.cl_req_valid) req_addr_q <= bus.cl_req_addr;
            if (state_q == LOOKUP) begin
                if (hit) begin
                    rsp_data_q <= hit_word;
                    rsp_hit_q  <= 1'b1;
                    hit_cnt_q  <= sat_inc(hit_cnt_q);
                end else begin
                    miss_cnt_q <= sat_inc(miss_cnt_q);
                end
            end
            if (state_q == FILL) begin
                rsp_data_q <= fill_word;
                rsp_hit_q  <= 1'b0;
            end
        end
    end

    // The captured fill line is pure data and needs no reset.
    always_ff @(posedge clk) begin
        if (state_q == MISS_WAIT && bus.l2_ack) fill_line_q <= bus.l2_data;
    end

    assign bus.cl_req_ready = (state_q == IDLE);
    assign bus.cl_rsp_valid = (state_q == RESP);
    assign bus.cl_rsp_data  = rsp_data_q;
    assign bus.cl_rsp_addr  = req_addr_q;
    assign bus.cl_rsp_hit   = rsp_hit_q;
    assign bus.l2_req_valid = (state_q == MISS_REQ);
    assign bus.l2_req_addr  = {req_addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign err_stray_ack    = err_q;
    assign hit_cnt          = hit_cnt_q;
    assign miss_cnt         = miss_cnt_q;
endmodule

// File: tb/tb_l1_fill_return_ctrl.sv
// Directed bench for l1_fill_return_ctrl: miss/hit/conflict, backpressure, invalidate,
// stray ack, reset during a miss and counter saturation (counters narrowed to 3 bits).
module tb_l1_fill_return_ctrl;
    localparam int ADDR_W  = 16;
    localparam int WORD_W  = 32;
    localparam int LINE_W  = 256;
    localparam int NLINES  = 32;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst;
    logic inv_all;
    logic err_stray_ack;
    logic [CNT_W-1:0] hit_cnt, miss_cnt;

    int total = 0;
    int bad   = 0;
    int exp_hit  = 0;
    int exp_miss = 0;

    l1_fill_return_ctrl_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .LINE_W(LINE_W)) bus_if ();

    l1_fill_return_ctrl #(
        .ADDR_W(ADDR_W), .WORD_W(WORD_W), .LINE_W(LINE_W), .NUM_LINES(NLINES), .CNT_W(CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus_if),
        .inv_all       (inv_all),
        .err_stray_ack (err_stray_ack),
        .hit_cnt       (hit_cnt),
        .miss_cnt      (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [LINE_W-1:0] mk_line(input logic [31:0] base);
        logic [LINE_W-1:0] l;
        l = '0;
        for (int k = 0; k < LINE_W / WORD_W; k++) l[k*WORD_W +: WORD_W] = base + 32'(k);
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic [ADDR_W-1:0] a);
        for (int i = 0; i < 20 && bus_if.cl_req_ready !== 1'b1; i++) tick();
        check("req_ready", 64'(bus_if.cl_req_ready), 64'd1);
        bus_if.cl_req_valid = 1'b1;
        bus_if.cl_req_addr  = a;
        tick();
        bus_if.cl_req_valid = 1'b0;
        bus_if.cl_req_addr  = '0;
        check("lookup_no_l2", 64'(bus_if.l2_req_valid), 64'd0);
        check("lookup_no_rsp", 64'(bus_if.cl_rsp_valid), 64'd0);
    endtask

    task automatic l2_handshake(input logic [ADDR_W-1:0] line_addr);
        for (int i = 0; i < 10 && bus_if.l2_req_valid !== 1'b1; i++) tick();
        check("l2_req_valid", 64'(bus_if.l2_req_valid), 64'd1);
        check("l2_req_addr", 64'(bus_if.l2_req_addr), 64'(line_addr));
        bus_if.l2_req_ready = 1'b1;
        tick();
        bus_if.l2_req_ready = 1'b0;
        check("wait_no_l2_req", 64'(bus_if.l2_req_valid), 64'd0);
    endtask

    task automatic l2_ack_pulse(input logic [LINE_W-1:0] line);
        bus_if.l2_data = line;
        bus_if.l2_ack  = 1'b1;
        tick();
        bus_if.l2_ack  = 1'b0;
        bus_if.l2_data = '0;
    endtask

    task automatic expect_rsp(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic h);
        check("rsp_valid", 64'(bus_if.cl_rsp_valid), 64'd1);
        check("rsp_data", 64'(bus_if.cl_rsp_data), 64'(d));
        check("rsp_addr", 64'(bus_if.cl_rsp_addr), 64'(a));
        check("rsp_hit", 64'(bus_if.cl_rsp_hit), 64'(h));
        check("hit_cnt", 64'(hit_cnt), 64'(exp_hit));
        check("miss_cnt", 64'(miss_cnt), 64'(exp_miss));
        bus_if.cl_rsp_ready = 1'b1;
        tick();
        bus_if.cl_rsp_ready = 1'b0;
        check("rsp_done", 64'(bus_if.cl_rsp_valid), 64'd0);
    endtask

    task automatic do_miss(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] line,
                           input logic [31:0] d);
        send_req(a);
        if (exp_miss < CNT_MAX) exp_miss++;
        tick();
        l2_handshake({a[ADDR_W-1:3], 3'b000});
        tick();
        check("wait_no_rsp", 64'(bus_if.cl_rsp_valid), 64'd0);
        l2_ack_pulse(line);
        check("fill_no_rsp", 64'(bus_if.cl_rsp_valid), 64'd0);
        tick();
        expect_rsp(a, d, 1'b0);
    endtask

    task automatic do_hit(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        send_req(a);
        if (exp_hit < CNT_MAX) exp_hit++;
        tick();
        check("hit_no_l2", 64'(bus_if.l2_req_valid), 64'd0);
        expect_rsp(a, d, 1'b1);
    endtask

    initial begin
        logic [LINE_W-1:0] line_a, line_b, line_c;
        line_a = mk_line(32'hA000_0000);
        line_b = mk_line(32'hB000_0000);
        line_c = mk_line(32'hC000_0000);
        rst = 1'b1;
        inv_all = 1'b0;
        bus_if.cl_req_valid = 1'b0;
        bus_if.cl_req_addr  = '0;
        bus_if.cl_rsp_ready = 1'b0;
        bus_if.l2_req_ready = 1'b0;
        bus_if.l2_ack       = 1'b0;
        bus_if.l2_data      = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_req_ready", 64'(bus_if.cl_req_ready), 64'd1);
        check("rst_rsp_valid", 64'(bus_if.cl_rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(bus_if.cl_rsp_data), 64'd0);
        check("rst_l2_req", 64'(bus_if.l2_req_valid), 64'd0);
        check("rst_err", 64'(err_stray_ack), 64'd0);
        check("rst_cnts", 64'({hit_cnt, miss_cnt}), 64'd0);

        // Cold miss with L2 backpressure on the line request
        send_req(16'h1234);
        exp_miss++;
        tick();
        for (int i = 0; i < 2; i++) begin
            check("l2_hold_valid", 64'(bus_if.l2_req_valid), 64'd1);
            check("l2_hold_addr", 64'(bus_if.l2_req_addr), 64'h1230);
            tick();
        end
        l2_handshake(16'h1230);
        tick();
        tick();
        l2_ack_pulse(line_a);
        tick();
        expect_rsp(16'h1234, 32'hA000_0004, 1'b0);

        // Hit
        do_hit(16'h1237, 32'hA000_0007);

        // Response backpressure for 5 cycles
        send_req(16'h1235);
        exp_hit++;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(bus_if.cl_rsp_valid), 64'd1);
            check("bp_data", 64'(bus_if.cl_rsp_data), 64'hA000_0005);
            check("bp_addr", 64'(bus_if.cl_rsp_addr), 64'h1235);
            check("bp_hit", 64'(bus_if.cl_rsp_hit), 64'd1);
            check("bp_req_ready", 64'(bus_if.cl_req_ready), 64'd0);
            tick();
        end
        expect_rsp(16'h1235, 32'hA000_0005, 1'b1);
        check("bp_back_idle", 64'(bus_if.cl_req_ready), 64'd1);

        // Conflict on index 6
        do_miss(16'h5634, line_b, 32'hB000_0004);
        do_miss(16'h1234, line_a, 32'hA000_0004);
        check("conflict_miss3", 64'(miss_cnt), 64'd3);

        // Hit, then global invalidate forces a miss
        do_hit(16'h1237, 32'hA000_0007);
        inv_all = 1'b1;
        tick();
        inv_all = 1'b0;
        do_miss(16'h1237, line_a, 32'hA000_0007);

        // Stray ack in IDLE: pulse, no array write
        l2_ack_pulse(line_c);
        check("stray_pulse", 64'(err_stray_ack), 64'd1);
        tick();
        check("stray_one_cycle", 64'(err_stray_ack), 64'd0);
        do_hit(16'h1237, 32'hA000_0007);

        // inv_all coincident with FILL: response still returned, line left invalid
        send_req(16'h5634);
        exp_miss++;
        tick();
        l2_handshake(16'h5630);
        l2_ack_pulse(line_b);
        inv_all = 1'b1;
        tick();
        inv_all = 1'b0;
        expect_rsp(16'h5634, 32'hB000_0004, 1'b0);
        do_miss(16'h5634, line_b, 32'hB000_0004);

        // Reset while waiting for L2, then the late ack is stray
        send_req(16'h1234);
        tick();
        l2_handshake(16'h1230);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_hit  = 0;
        exp_miss = 0;
        check("mid_rst_req_ready", 64'(bus_if.cl_req_ready), 64'd1);
        check("mid_rst_outs", 64'({bus_if.cl_rsp_valid, bus_if.l2_req_valid, bus_if.cl_rsp_hit}), 64'd0);
        check("mid_rst_data", 64'(bus_if.cl_rsp_data), 64'd0);
        check("mid_rst_addr", 64'(bus_if.cl_rsp_addr), 64'd0);
        check("mid_rst_cnts", 64'({hit_cnt, miss_cnt}), 64'd0);
        l2_ack_pulse(line_c);
        check("late_ack_stray", 64'(err_stray_ack), 64'd1);
        do_miss(16'h1234, line_a, 32'hA000_0004);

        // Hit counter saturation
        for (int i = 0; i < CNT_MAX + 2; i++) do_hit(16'h1234, 32'hA000_0004);
        check("hit_sat", 64'(hit_cnt), 64'(CNT_MAX));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
